// File: rtl/s2c_pkg.sv
// Shared constants and types for the s2c function-call sequencer.
package s2c_pkg;

  // Number of 32-bit data words returned with every call.
  localparam int S2C_DATA_SIZE = 16;

  // Function codes carried on req_fn / cmd_fn.
  localparam logic [31:0] FN_SETUP     = 32'd0;
  localparam logic [31:0] FN_CALL      = 32'd1;
  localparam logic [31:0] FN_CHECK_END = 32'd2;

  // Return code substituted when the bridge never answers.
  localparam logic [31:0] RET_TIMEOUT  = 32'hFFFF_FFFF;

  // Call lifecycle: pick a requester, present the call, wait, hand back.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } s2c_state_e;

  // One-hot vector with a single bit set at position idx.
  function automatic logic [7:0] onehot8(input int unsigned idx);
    logic [7:0] v;
    v = '0;
    v[idx[2:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/s2c_call_sequencer_if.sv
// Bundle of requester-side, bridge-side and status signals of the sequencer.
//
// Handshake rule for every valid/ready pair in this bundle: a transfer happens
// on a rising clk edge where both valid and ready are 1. The valid side holds
// valid and its payload unchanged until that edge and never waits on ready
// before raising valid. done_valid is the exception: a bare one-cycle pulse
// with no ready.
//
// The sequencer connects through modport slave; the agents/bridge side that
// drives requests and completions uses modport master.
interface s2c_call_sequencer_if
  import s2c_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_SIZE = S2C_DATA_SIZE
) ();

  // Requester side
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*32-1:0]     req_id;
  logic [N_REQ*32-1:0]     req_fn;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [31:0]             rsp_ret;
  logic [32*DATA_SIZE-1:0] rsp_data;

  // Bridge side
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [31:0]             cmd_id;
  logic [31:0]             cmd_fn;
  logic                    done_valid;
  logic [31:0]             done_ret;
  logic [32*DATA_SIZE-1:0] done_data;

  // Status and debug
  logic                    busy;
  logic                    err_timeout;
  logic                    err_stray;
  s2c_state_e              dbg_state;

  modport slave (
    input  req_valid, req_id, req_fn, rsp_ready,
    input  cmd_ready, done_valid, done_ret, done_data,
    output req_ready, rsp_valid, rsp_ret, rsp_data,
    output cmd_valid, cmd_id, cmd_fn,
    output busy, err_timeout, err_stray, dbg_state
  );

  modport master (
    output req_valid, req_id, req_fn, rsp_ready,
    output cmd_ready, done_valid, done_ret, done_data,
    input  req_ready, rsp_valid, rsp_ret, rsp_data,
    input  cmd_valid, cmd_id, cmd_fn,
    input  busy, err_timeout, err_stray, dbg_state
  );

endinterface

// File: rtl/s2c_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer,
// wrapping around. The pointer register is owned by the caller.
module s2c_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Scan from the farthest offset down to the pointer so the closest valid
  // requester is the last one written and therefore wins.
  always_comb begin
    o_idx   = '0;
    o_grant = '0;
    o_any   = |i_req;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      if (i_req[(int'(i_ptr) + off) % N_REQ]) begin
        o_idx = IDX_W'((int'(i_ptr) + off) % N_REQ);
      end
    end
    if (o_any) begin
      o_grant[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/s2c_call_sequencer.sv
// Shares one s2c function-call channel among N_REQ requesters: round-robin
// grant, a single call in flight, response routed back to the issuer, and an
// optional per-call timeout that completes the call with RET_TIMEOUT.
module s2c_call_sequencer
  import s2c_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_SIZE   = S2C_DATA_SIZE,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  s2c_call_sequencer_if.slave bus
);

  localparam int   IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int   CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int   TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic TO_EN   = (TIMEOUT_CYC > 0);

  // State and datapath registers
  s2c_state_e              r_state;
  logic [IDX_W-1:0]        r_ptr;
  logic [N_REQ-1:0]        r_grant;
  logic [N_REQ-1:0]        r_req_ready;
  logic [31:0]             r_id;
  logic [31:0]             r_fn;
  logic                    r_cmd_valid;
  logic [CNT_W-1:0]        r_cnt;
  logic [N_REQ-1:0]        r_rsp_valid;
  logic [31:0]             r_rsp_ret;
  logic [32*DATA_SIZE-1:0] r_rsp_data;
  logic                    r_err_timeout;
  logic                    r_err_stray;

  // Arbiter result and FSM decode
  logic [N_REQ-1:0]        w_grant;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_any;
  logic [IDX_W-1:0]        w_ptr_nxt;
  logic                    w_cnt_last;
  s2c_state_e              w_state_nxt;
  logic                    w_take_req;
  logic                    w_cmd_fire;
  logic                    w_take_done;
  logic                    w_take_timeout;
  logic                    w_rsp_fire;

  s2c_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // After a grant, the requester just served drops to lowest priority.
  assign w_ptr_nxt  = (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;

  // Last allowed WAIT cycle; never true when the timeout is disabled.
  assign w_cnt_last = TO_EN && (r_cnt == CNT_W'(TO_LAST));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and the single-cycle strobes that steer the datapath.
  always_comb begin
    w_state_nxt    = r_state;
    w_take_req     = 1'b0;
    w_cmd_fire     = 1'b0;
    w_take_done    = 1'b0;
    w_take_timeout = 1'b0;
    w_rsp_fire     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_take_req  = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (r_cmd_valid && bus.cmd_ready) begin
          w_cmd_fire  = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A real completion beats a timeout that expires on the same cycle.
        if (bus.done_valid) begin
          w_take_done = 1'b1;
          w_state_nxt = RESP;
        end else if (w_cnt_last) begin
          w_take_timeout = 1'b1;
          w_state_nxt    = RESP;
        end
      end
      RESP: begin
        // Only the granted requester's rsp_ready can retire the response.
        if (|(r_rsp_valid & bus.rsp_ready)) begin
          w_rsp_fire  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Grant capture, round-robin pointer and the one-cycle req_ready pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_grant     <= '0;
      r_req_ready <= '0;
      r_id        <= '0;
      r_fn        <= '0;
    end else begin
      r_req_ready <= '0;
      if (w_take_req) begin
        r_ptr       <= w_ptr_nxt;
        r_grant     <= w_grant;
        r_req_ready <= w_grant;
        r_id        <= bus.req_id[32*int'(w_idx) +: 32];
        r_fn        <= bus.req_fn[32*int'(w_idx) +: 32];
      end
    end
  end

  // Present the call once the requester handshake has completed, hold it until
  // the bridge accepts, then count WAIT cycles for the timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cmd_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (r_state == ISSUE && |r_req_ready) begin
        r_cmd_valid <= 1'b1;
      end
      if (w_cmd_fire) begin
        r_cmd_valid <= 1'b0;
        r_cnt       <= '0;
      end else if (r_state == WAIT && !bus.done_valid && !w_cnt_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Response registers, routed to the issuer and held until it consumes them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid   <= '0;
      r_rsp_ret     <= '0;
      r_rsp_data    <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= 1'b0;
      if (w_take_done) begin
        r_rsp_valid <= r_grant;
        r_rsp_ret   <= bus.done_ret;
        r_rsp_data  <= bus.done_data;
      end else if (w_take_timeout) begin
        r_rsp_valid   <= r_grant;
        r_rsp_ret     <= RET_TIMEOUT;
        r_rsp_data    <= '0;
        r_err_timeout <= 1'b1;
      end else if (w_rsp_fire) begin
        r_rsp_valid <= '0;
      end
    end
  end

  // A completion arriving when no call is waiting is dropped and flagged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_stray <= 1'b0;
    end else begin
      r_err_stray <= bus.done_valid && (r_state != WAIT);
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_ret     = r_rsp_ret;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.cmd_valid   = r_cmd_valid;
  assign bus.cmd_id      = r_id;
  assign bus.cmd_fn      = r_fn;
  assign bus.busy        = (r_state != IDLE);
  assign bus.err_timeout = r_err_timeout;
  assign bus.err_stray   = r_err_stray;
  assign bus.dbg_state   = r_state;

endmodule
